// File: rtl/bsg_blackparrot_tag_cfg_sender_pkg.sv
// Shared definitions for the bsg_tag configuration sender.
//   bsg_tag_sender_state_e : sender FSM states
//   safe_clog2             : $clog2 that never returns 0 (field widths stay >= 1)
//   tag_header_len         : bits in a tag packet header (start + len + dnr + node id)
package bsg_chip_pkg;

  typedef enum logic [1:0] {
    e_init_ones  = 2'd0,
    e_init_zeros = 2'd1,
    e_idle       = 2'd2,
    e_send       = 2'd3
  } bsg_tag_sender_state_e;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int tag_header_len(input int len_width, input int node_id_width);
    return 1 + len_width + 1 + node_id_width;
  endfunction

endpackage

// File: rtl/bsg_blackparrot_tag_cfg_sender_if.sv
// Parallel configuration-write port of the tag sender (ready/valid).
//   v_i              : write valid (master -> slave)
//   ready_o          : sender can accept a write (slave -> master)
//   node_id_i        : destination tag client
//   data_not_reset_i : 1 = data write, 0 = client reset packet
//   len_i            : payload bit count
//   data_i           : payload, only [len_i-1:0] is sent
interface bsg_blackparrot_tag_cfg_sender_if
  import bsg_chip_pkg::*;
#(
  parameter int max_payload_width_p = 16,
  parameter int node_id_width_p     = 2,
  parameter int len_width_p         = safe_clog2(max_payload_width_p + 1)
);
  logic                           v_i;
  logic                           ready_o;
  logic [node_id_width_p-1:0]     node_id_i;
  logic                           data_not_reset_i;
  logic [len_width_p-1:0]         len_i;
  logic [max_payload_width_p-1:0] data_i;

  modport master (
    output v_i, node_id_i, data_not_reset_i, len_i, data_i,
    input  ready_o
  );

  modport slave (
    input  v_i, node_id_i, data_not_reset_i, len_i, data_i,
    output ready_o
  );
endinterface

// File: rtl/bsg_blackparrot_tag_pkt_serializer.sv
// Parallel-in, LSB-first serial-out shift register for one tag packet.
//   clk_i, reset_i : clock, synchronous active-high reset
//   load_i         : capture pkt_i and start shifting
//   len_i          : packet bit count (header + payload)
//   pkt_i          : packet, first bit in [0]; bits at/above len_i must be 0
//   bit_o          : next bit to put on the line (pkt_i[0] while loading)
//   last_o         : no shifts left; the line is carrying the trailing guard 0
module bsg_blackparrot_tag_pkt_serializer #(
  parameter int width_p     = 25,
  parameter int cnt_width_p = 5
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic [cnt_width_p-1:0] len_i,
  input  logic [width_p-1:0]     pkt_i,
  output logic                   bit_o,
  output logic                   last_o
);

  logic [width_p-1:0]     sr_r;
  logic [cnt_width_p-1:0] cnt_r;

  // Bit 0 goes straight to the line on the load edge, so the register keeps
  // the remaining bits. Counting len_i shifts (not len_i-1) shifts one zero
  // beyond the packet end, which becomes the guard bit for free.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_r  <= '0;
      cnt_r <= '0;
    end else if (load_i) begin
      sr_r  <= pkt_i >> 1;
      cnt_r <= len_i;
    end else if (cnt_r != '0) begin
      sr_r  <= sr_r >> 1;
      cnt_r <= cnt_r - 1'b1;
    end
  end

  assign bit_o  = load_i ? pkt_i[0] : sr_r[0];
  assign last_o = (cnt_r == '0);

endmodule

// File: rtl/bsg_blackparrot_tag_cfg_sender.sv
// Transmitting end of the bsg_tag config channel: emits the tag-network init
// sequence after reset, then serializes each accepted write into a packet.
//   clk_i, reset_i : clock, synchronous active-high reset
//   cfg            : configuration write port (slave side)
//   tag_o          : registered serial tag line, idles at 0
//   busy_o         : init in progress or packet in flight (= ~ready)
//
// state        | meaning
// e_init_ones  | tag_o held 1 for init_ones_p cycles
// e_init_zeros | tag_o held 0 for init_zeros_p cycles
// e_idle       | ready, tag_o 0, waiting for a write
// e_send       | shifting packet bits, then one guard 0
module bsg_blackparrot_tag_cfg_sender
  import bsg_chip_pkg::*;
#(
  parameter int els_p               = 3,
  parameter int node_id_width_p     = safe_clog2(els_p),
  parameter int max_payload_width_p = 16,
  parameter int init_ones_p         = 8,
  parameter int init_zeros_p        = 4
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  bsg_blackparrot_tag_cfg_sender_if.slave     cfg,
  output logic                                tag_o,
  output logic                                busy_o
);

  localparam int len_width_lp      = safe_clog2(max_payload_width_p + 1);
  localparam int hdr_len_lp        = tag_header_len(len_width_lp, node_id_width_p);
  localparam int pkt_width_lp      = hdr_len_lp + max_payload_width_p;
  localparam int bit_cnt_width_lp  = safe_clog2(pkt_width_lp + 1);
  localparam int init_max_lp       = (init_ones_p > init_zeros_p) ? init_ones_p : init_zeros_p;
  localparam int init_cnt_width_lp = safe_clog2(init_max_lp + 1);

  bsg_tag_sender_state_e         state_r, state_n;
  logic [init_cnt_width_lp-1:0]  init_cnt_r, init_cnt_n;
  logic                          tag_r, tag_n;
  logic                          ready;
  logic                          load;
  logic                          ser_bit, ser_last;

  logic [len_width_lp-1:0]        len_clamped;
  logic [max_payload_width_p-1:0] payload_mask;
  logic [pkt_width_lp-1:0]        pkt;
  logic [bit_cnt_width_lp-1:0]    pkt_bits;

  // Oversized lengths are clamped so the length field and the bit count agree.
  assign len_clamped  = (cfg.len_i > len_width_lp'(max_payload_width_p))
                        ? len_width_lp'(max_payload_width_p) : cfg.len_i;
  // Masking unsent payload bits keeps the bits past the packet end at zero,
  // which the serializer relies on for the guard bit.
  assign payload_mask = ~({max_payload_width_p{1'b1}} << len_clamped);
  assign pkt          = {cfg.data_i & payload_mask, cfg.node_id_i,
                         cfg.data_not_reset_i, len_clamped, 1'b1};
  assign pkt_bits     = bit_cnt_width_lp'(hdr_len_lp) + bit_cnt_width_lp'(len_clamped);

  bsg_blackparrot_tag_pkt_serializer #(
    .width_p     (pkt_width_lp),
    .cnt_width_p (bit_cnt_width_lp)
  ) serializer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (load),
    .len_i   (pkt_bits),
    .pkt_i   (pkt),
    .bit_o   (ser_bit),
    .last_o  (ser_last)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r    <= e_init_ones;
      init_cnt_r <= '0;
      tag_r      <= 1'b0;
    end else begin
      state_r    <= state_n;
      init_cnt_r <= init_cnt_n;
      tag_r      <= tag_n;
    end
  end

  // tag_n is the line value for the next cycle; init_cnt counts cycles of the
  // current phase already driven onto the line.
  always_comb begin
    state_n    = state_r;
    init_cnt_n = init_cnt_r;
    tag_n      = 1'b0;
    load       = 1'b0;
    unique case (state_r)
      e_init_ones: begin
        if (init_cnt_r == init_cnt_width_lp'(init_ones_p)) begin
          state_n    = e_init_zeros;
          init_cnt_n = init_cnt_width_lp'(1);
        end else begin
          init_cnt_n = init_cnt_r + 1'b1;
          tag_n      = 1'b1;
        end
      end
      e_init_zeros: begin
        if (init_cnt_r == init_cnt_width_lp'(init_zeros_p)) begin
          state_n    = e_idle;
          init_cnt_n = '0;
        end else begin
          init_cnt_n = init_cnt_r + 1'b1;
        end
      end
      e_idle: begin
        if (cfg.v_i) begin
          state_n = e_send;
          load    = 1'b1;
          tag_n   = ser_bit;
        end
      end
      e_send: begin
        if (ser_last) state_n = e_idle;
        else          tag_n   = ser_bit;
      end
      default: state_n = e_init_ones;
    endcase
  end

  assign ready       = (state_r == e_idle);
  assign cfg.ready_o = ready;
  assign busy_o      = ~ready;
  assign tag_o       = tag_r;

  always_ff @(posedge clk_i) begin
    if (!reset_i && cfg.v_i && ready)
      assert (cfg.len_i <= len_width_lp'(max_payload_width_p))
        else $warning("len_i=%0d above max_payload_width_p=%0d, clamped",
                      cfg.len_i, max_payload_width_p);
  end

endmodule

// File: tb/tb_bsg_blackparrot_tag_cfg_sender.sv
module tb_bsg_blackparrot_tag_cfg_sender;
  import bsg_chip_pkg::*;

  localparam int NW   = 2;
  localparam int MAXP = 16;
  localparam int LW   = 5;
  localparam int ONES = 8;
  localparam int ZER  = 4;

  logic clk_i = 1'b0;
  logic reset_i;
  logic tag_o, busy_o;

  bsg_blackparrot_tag_cfg_sender_if #(
    .max_payload_width_p (MAXP),
    .node_id_width_p     (NW),
    .len_width_p         (LW)
  ) cfg_if ();

  bsg_blackparrot_tag_cfg_sender #(
    .els_p               (3),
    .node_id_width_p     (NW),
    .max_payload_width_p (MAXP),
    .init_ones_p         (ONES),
    .init_zeros_p        (ZER)
  ) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .cfg     (cfg_if),
    .tag_o   (tag_o),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the line is a queue of bits still to be driven. Ready is
  // simply "nothing queued and out of reset".
  bit q[$];
  bit m_tag = 1'b0;
  bit m_rdy = 1'b0;
  bit m_started = 1'b0;
  bit cmp_en = 1'b0;
  int m_len;

  always @(posedge clk_i) begin
    if (reset_i) begin
      q.delete();
      m_started = 1'b0;
      m_tag = 1'b0;
      m_rdy = 1'b0;
    end else begin
      if (!m_started) begin
        m_started = 1'b1;
        for (int i = 0; i < ONES; i++) q.push_back(1'b1);
        for (int i = 0; i < ZER; i++)  q.push_back(1'b0);
      end else if (m_rdy && cfg_if.v_i) begin
        m_len = (int'(cfg_if.len_i) > MAXP) ? MAXP : int'(cfg_if.len_i);
        q.push_back(1'b1);
        for (int i = 0; i < LW; i++) q.push_back(m_len[i]);
        q.push_back(cfg_if.data_not_reset_i);
        for (int i = 0; i < NW; i++) q.push_back(cfg_if.node_id_i[i]);
        for (int i = 0; i < m_len; i++) q.push_back(cfg_if.data_i[i]);
        q.push_back(1'b0);
      end
      if (q.size() > 0) begin
        m_tag = q.pop_front();
        m_rdy = 1'b0;
      end else begin
        m_tag = 1'b0;
        m_rdy = 1'b1;
      end
    end
  end

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("tag_o", 32'(tag_o), 32'(m_tag));
      check("ready_o", 32'(cfg_if.ready_o), 32'(m_rdy));
      check("busy_o", 32'(busy_o), 32'(!m_rdy));
    end
  end

  task automatic wait_ready(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (cfg_if.ready_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic check_init(input string name);
    logic [31:0] cap = '0;
    for (int c = 1; c <= ONES + ZER; c++) begin
      @(negedge clk_i);
      cap = {cap[30:0], tag_o};
    end
    check({name, "_tag_seq"}, cap, 32'b1111_1111_0000);
    @(negedge clk_i);
    check({name, "_ready_c13"}, 32'(cfg_if.ready_o), 32'd1);
  endtask

  task automatic drive_fields(input logic [NW-1:0] nid, input logic dnr,
                              input logic [LW-1:0] len, input logic [MAXP-1:0] data);
    cfg_if.node_id_i        = nid;
    cfg_if.data_not_reset_i = dnr;
    cfg_if.len_i            = len;
    cfg_if.data_i           = data;
  endtask

  task automatic scramble_fields();
    drive_fields(NW'($urandom), 1'($urandom), LW'($urandom_range(0, MAXP)), MAXP'($urandom));
  endtask

  // Sends one write, captures nbits of tag_o (first bit ends in the MSB of
  // the nbits window), checks the guard 0 and the cycle ready_o returns.
  task automatic send_capture(input string name, input logic [NW-1:0] nid, input logic dnr,
                              input logic [LW-1:0] len, input logic [MAXP-1:0] data,
                              input int nbits, input logic [31:0] exp_bits, input int exp_rdy);
    logic [31:0] cap = '0;
    int k;
    bit ok = 1'b0;
    wait_ready(name);
    cfg_if.v_i = 1'b1;
    drive_fields(nid, dnr, len, data);
    @(posedge clk_i);
    #1;
    cfg_if.v_i = 1'b0;
    scramble_fields();
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk_i);
      cap = {cap[30:0], tag_o};
    end
    check({name, "_bits"}, cap, exp_bits);
    @(negedge clk_i);
    check({name, "_guard"}, 32'(tag_o), 32'd0);
    k = nbits + 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      k++;
      if (cfg_if.ready_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    else     check({name, "_ready_latency"}, 32'(k), 32'(exp_rdy));
  endtask

  initial begin
    int k;
    bit ok;
    reset_i   = 1'b1;
    cfg_if.v_i = 1'b0;
    drive_fields('0, 1'b0, '0, '0);
    @(posedge clk_i);
    cmp_en = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_tag", 32'(tag_o), 32'd0);
    check("reset_busy", 32'(busy_o), 32'd1);
    reset_i = 1'b0;
    check_init("init");

    send_capture("single", 2'd2, 1'b1, 5'd7, 16'hFF55, 16, 32'b1_11100_1_01_1010101, 18);
    send_capture("zero_len", 2'd1, 1'b0, 5'd0, 16'hBEEF, 9, 32'b1_00000_0_10, 11);

    // Back-to-back with v_i held high.
    wait_ready("b2b");
    cfg_if.v_i = 1'b1;
    drive_fields(2'd0, 1'b1, 5'd7, MAXP'($urandom));
    @(posedge clk_i);
    #1;
    drive_fields(2'd1, 1'b1, 5'd7, MAXP'($urandom));
    k = 0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk_i);
      k++;
      if (cfg_if.ready_o === 1'b1) begin ok = 1'b1; break; end
    end
    if (!ok) check("b2b_timeout", 32'd0, 32'd1);
    else     check("b2b_spacing", 32'(k), 32'(tag_header_len(LW, NW) + 7 + 2));
    @(posedge clk_i);
    #1;
    cfg_if.v_i = 1'b0;

    // Reset while packet bit 5 is on the line.
    wait_ready("abort");
    cfg_if.v_i = 1'b1;
    drive_fields(2'd2, 1'b1, 5'd10, 16'h0155);
    @(posedge clk_i);
    #1;
    cfg_if.v_i = 1'b0;
    repeat (6) @(negedge clk_i);
    check("abort_bit5", 32'(tag_o), 32'd0);
    reset_i = 1'b1;
    @(negedge clk_i);
    check("abort_tag", 32'(tag_o), 32'd0);
    check("abort_ready", 32'(cfg_if.ready_o), 32'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    check_init("reinit");
    send_capture("after_abort", 2'd1, 1'b0, 5'd0, 16'h1234, 9, 32'b1_00000_0_10, 11);

    // Oversized length: clamped to 16 in both field and bit count.
    send_capture("clamp", 2'd0, 1'b1, 5'd20, 16'hA5C3, 25,
                 32'b1_00001_1_00_1100001110100101, 27);

    // Random traffic, checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk_i);
      cfg_if.v_i = ($urandom_range(0, 2) == 0);
      scramble_fields();
    end
    @(negedge clk_i);
    cfg_if.v_i = 1'b0;
    wait_ready("final");
    repeat (4) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
